// File: rtl/digi_source_if.sv
// Bus bundle for digi_source: table-write port, playback control and status.
interface digi_source_if #(
  parameter int DEPTH = 8,
  parameter int TW    = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic          wr_level;
  logic [TW-1:0] wr_dur;
  logic          wr_ready;
  logic          clr;
  logic          start;
  logic          repeat_en;
  logic          abort;
  logic          q;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  modport master (
    output wr_en, wr_level, wr_dur, clr, start, repeat_en, abort,
    input  wr_ready, q, busy, done, count
  );

  modport slave (
    input  wr_en, wr_level, wr_dur, clr, start, repeat_en, abort,
    output wr_ready, q, busy, done, count
  );
endinterface

// File: rtl/digi_source.sv
// Programmable digital pattern source: a small table of {level, hold} entries
// played back on q, optionally looping, with abort and a completion pulse.
//
// state  | meaning
// IDLE   | q = INIT, table writable, waiting for start
// RUN    | q = level of current entry, hold timer counting down
module digi_source #(
  parameter int DEPTH = 8,
  parameter int TW    = 16,
  parameter bit INIT  = 1'b0
) (
  input logic         clk,
  input logic         rst,
  digi_source_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_lvl [DEPTH];
  logic [TW-1:0] r_dur [DEPTH];
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_tmr;
  logic          r_done;

  logic          w_done_nxt;
  logic          w_load_first;
  logic          w_advance;
  logic          w_wr_fire;
  logic          w_tc;
  logic          w_last;
  logic [IW-1:0] w_idx_inc;

  assign bus.wr_ready = (r_state == S_IDLE) && (r_count < CW'(DEPTH));
  // clr wins over a same-cycle write
  assign w_wr_fire    = bus.wr_en && bus.wr_ready && !bus.clr && !rst;
  // dur of 0 or 1 both end the entry after one cycle
  assign w_tc         = (r_tmr <= TW'(1));
  assign w_last       = ({1'b0, r_idx} + CW'(1)) == r_count;
  assign w_idx_inc    = r_idx + IW'(1);

  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = r_done;
  assign bus.count = r_count;
  assign bus.q     = (r_state == S_RUN) ? r_lvl[r_idx] : INIT;

  // State register and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state decode: start, per-entry advance, wrap, finish, abort
  always_comb begin
    w_state_nxt  = r_state;
    w_done_nxt   = 1'b0;
    w_load_first = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.abort && (r_count != '0)) begin
          w_state_nxt  = S_RUN;
          w_load_first = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_tc) begin
          if (!w_last) begin
            w_advance = 1'b1;
          end else if (bus.repeat_en) begin
            w_load_first = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Entry count: cleared by rst or by clr while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if ((r_state == S_IDLE) && bus.clr) begin
      r_count <= '0;
    end else if (w_wr_fire) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Pattern table storage; contents survive rst, clr and abort
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_lvl[r_count[IW-1:0]] <= bus.wr_level;
      r_dur[r_count[IW-1:0]] <= bus.wr_dur;
    end
  end

  // Entry index and hold down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_tmr <= '0;
    end else if (w_load_first) begin
      r_idx <= '0;
      r_tmr <= r_dur[0];
    end else if (w_advance) begin
      r_idx <= w_idx_inc;
      r_tmr <= r_dur[w_idx_inc];
    end else if (r_state == S_RUN) begin
      r_tmr <= r_tmr - TW'(1);
    end
  end
endmodule

// File: tb/tb_digi_source.sv
// Directed bench for digi_source: a vector table for single-cycle behaviour
// plus hand-written sequences for repeat, abort and mid-run reset.
module tb_digi_source;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  digi_source_if #(.DEPTH(8), .TW(16)) bus ();

  digi_source #(.DEPTH(8), .TW(16), .INIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    bit          we;
    bit          lvl;
    logic [15:0] dur;
    bit          clr;
    bit          st;
    bit          rep;
    bit          ab;
    bit          eq;
    bit          ebusy;
    bit          edone;
    bit          erdy;
    int          ecount;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(string name, bit we, bit lvl, int dur, bit clr,
                             bit st, bit rep, bit ab, bit eq, bit ebusy,
                             bit edone, bit erdy, int ecount);
    vec_t r;
    r.name = name; r.we = we; r.lvl = lvl; r.dur = 16'(dur); r.clr = clr;
    r.st = st; r.rep = rep; r.ab = ab; r.eq = eq; r.ebusy = ebusy;
    r.edone = edone; r.erdy = erdy; r.ecount = ecount;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(bit we, bit lvl, int dur, bit clr, bit st, bit rep, bit ab);
    bus.wr_en     = we;
    bus.wr_level  = lvl;
    bus.wr_dur    = 16'(dur);
    bus.clr       = clr;
    bus.start     = st;
    bus.repeat_en = rep;
    bus.abort     = ab;
  endtask

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string name, bit eq, bit eb, bit ed, bit er, int ec);
    chk({name, ".q"},     int'(bus.q),        int'(eq));
    chk({name, ".busy"},  int'(bus.busy),     int'(eb));
    chk({name, ".done"},  int'(bus.done),     int'(ed));
    chk({name, ".ready"}, int'(bus.wr_ready), int'(er));
    chk({name, ".count"}, int'(bus.count),    ec);
  endtask

  task automatic wr(bit lvl, int dur);
    drv(1, lvl, dur, 0, 0, 0, 0);
    tick();
  endtask

  task automatic clear();
    drv(0, 0, 0, 1, 0, 0, 0);
    tick();
  endtask

  initial begin
    int dones;

    // basic two-entry pass: (1,3),(0,2)
    vt.push_back(v("w0",    1,1,3, 0,0,0,0, 0,0,0,1,1));
    vt.push_back(v("w1",    1,0,2, 0,0,0,0, 0,0,0,1,2));
    vt.push_back(v("k+1",   0,0,0, 0,1,0,0, 1,1,0,0,2));
    vt.push_back(v("k+2",   0,0,0, 0,0,0,0, 1,1,0,0,2));
    vt.push_back(v("k+3",   0,0,0, 0,0,0,0, 1,1,0,0,2));
    vt.push_back(v("k+4",   0,0,0, 0,0,0,0, 0,1,0,0,2));
    vt.push_back(v("k+5",   0,0,0, 0,0,0,0, 0,1,0,0,2));
    vt.push_back(v("k+6",   0,0,0, 0,0,0,0, 0,0,1,1,2));
    vt.push_back(v("k+7",   0,0,0, 0,0,0,0, 0,0,0,1,2));
    vt.push_back(v("clr",   0,0,0, 1,0,0,0, 0,0,0,1,0));
    // fill to DEPTH, drop the ninth, clear
    for (int i = 0; i < 8; i++)
      vt.push_back(v("fill", 1, i[0], i + 1, 0,0,0,0, 0,0,0, (i < 7), i + 1));
    vt.push_back(v("ninth", 1,1,7, 0,0,0,0, 0,0,0,0,8));
    vt.push_back(v("clr8",  0,0,0, 1,0,0,0, 0,0,0,1,0));
    vt.push_back(v("clrwr", 1,1,4, 1,0,0,0, 0,0,0,1,0));
    // dur = 0 entry holds one cycle
    vt.push_back(v("d0w0",  1,1,0, 0,0,0,0, 0,0,0,1,1));
    vt.push_back(v("d0w1",  1,0,2, 0,0,0,0, 0,0,0,1,2));
    vt.push_back(v("d0k1",  0,0,0, 0,1,0,0, 1,1,0,0,2));
    vt.push_back(v("d0k2",  0,0,0, 0,0,0,0, 0,1,0,0,2));
    vt.push_back(v("d0k3",  0,0,0, 0,0,0,0, 0,1,0,0,2));
    vt.push_back(v("d0k4",  0,0,0, 0,0,0,0, 0,0,1,1,2));
    // start with empty table is ignored
    vt.push_back(v("clr0",  0,0,0, 1,0,0,0, 0,0,0,1,0));
    vt.push_back(v("st0",   0,0,0, 0,1,0,0, 0,0,0,1,0));
    vt.push_back(v("st0b",  0,0,0, 0,0,0,0, 0,0,0,1,0));

    drv(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    drv(1, 1, 5, 0, 1, 0, 0);  // reset must override these
    tick();
    chk_all("reset", 0, 0, 0, 1, 0);
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_all("post_reset", 0, 0, 0, 1, 0);

    foreach (vt[i]) begin
      drv(vt[i].we, vt[i].lvl, int'(vt[i].dur), vt[i].clr, vt[i].st, vt[i].rep, vt[i].ab);
      tick();
      chk_all(vt[i].name, vt[i].eq, vt[i].ebusy, vt[i].edone, vt[i].erdy, vt[i].ecount);
    end

    // repeat: (1,1),(0,1) alternates with no gap, then drop repeat_en
    clear();
    wr(1, 1);
    wr(0, 1);
    drv(0, 0, 0, 0, 1, 1, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, 0, 0, 0, 1, 0);
      chk("rep.q", int'(bus.q), (i % 2 == 0) ? 1 : 0);
      chk("rep.busy", int'(bus.busy), 1);
      chk("rep.done", int'(bus.done), 0);
      tick();
    end
    chk("rep.q_e0", int'(bus.q), 1);
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rep.q_last", int'(bus.q), 0);
    chk("rep.busy_last", int'(bus.busy), 1);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      dones += int'(bus.done);
      if (i == 0) chk("rep.done_first", int'(bus.done), 1);
      chk("rep.busy_after", int'(bus.busy), 0);
    end
    chk("rep.done_count", dones, 1);

    // abort during entry 1, then replay from entry 0
    clear();
    wr(0, 2);
    wr(1, 3);
    wr(0, 2);
    drv(0, 0, 0, 0, 1, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("ab.q_e1", int'(bus.q), 1);
    drv(0, 0, 0, 0, 1, 0, 1);  // start alongside abort is ignored
    tick();
    chk_all("ab.next", 0, 0, 0, 1, 3);
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab.no_done", int'(bus.done), 0);
    end
    drv(0, 0, 0, 0, 1, 0, 1);  // abort beats start while idle too
    tick();
    chk("ab.idle_both", int'(bus.busy), 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("rp.q0", int'(bus.q), 0);
    chk("rp.busy", int'(bus.busy), 1);
    tick();
    chk("rp.q1", int'(bus.q), 0);
    tick();
    chk("rp.q2", int'(bus.q), 1);

    // reset mid-run
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst_run", 0, 0, 0, 1, 0);
    tick();
    chk_all("rst_run2", 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
